vm_change_dispenser: RTL and testbench
======================================

Name: vm_change_dispenser

Overview:
- Downstream stage of the vending machine controller; consumes its one-cycle delivery strobe and 4-bit change amount.
- Pays the change out through a coin hopper, one coin per valid/ready handshake.
- Picks coins greedily (Rs5, Rs2, Rs1), skipping empty hopper tubes, and flags any shortfall it cannot pay.

Parameters:
- COIN_GAP, 1: idle cycles after each accepted coin before the next is offered (0 = back-to-back).
- AMT_W, 4: width of the change amount and remaining counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- delivery  in  1  one-cycle strobe from the vending controller: product delivered, change valid.
- change  in  AMT_W  change owed in rupees; sampled only when delivery=1.
- hopper_empty  in  3  per-tube empty flags: [0]=Rs1, [1]=Rs2, [2]=Rs5.
- coin_ready  in  1  hopper accepts the offered coin.
- coin_valid  out  1  a coin is being offered.
- coin_type  out  2  coin code: 00 none, 01 Rs1, 10 Rs2, 11 Rs5.
- busy  out  1  a payout is in progress (state not IDLE).
- done  out  1  one-cycle pulse when a payout ends, whether complete or shortfall.
- remaining  out  AMT_W  rupees still owed in the current payout.
- shortfall  out  1  last payout could not complete; held until the next capture.
- overrun  out  1  sticky: a delivery was lost; cleared only by reset.
- states  out  3  current FSM state, for debug.

Behaviour:
- Reset value of every output and internal register is 0. Reset mid-payout aborts immediately; the pending slot and overrun are cleared.
- FSM encoding: IDLE=0, SELECT=1, ISSUE=2, GAP=3, DONE=4, FAULT=5.
- IDLE:
  - delivery=1 at edge N: load remaining<=change, clear shortfall.
  - If change!=0, go to SELECT. If change==0, go to DONE, so done pulses in cycle N+1 and no coin is issued.
- SELECT (one cycle):
  - Choose the largest d in {5,2,1} with d<=remaining and tube d not empty; latch coin_type and go to ISSUE.
  - If no such d exists, go to FAULT.
- ISSUE:
  - coin_valid=1 and coin_type is held stable until accepted, even if hopper_empty changes meanwhile.
  - On an edge with coin_ready=1: remaining<=remaining-d, coin_valid drops next cycle.
  - After acceptance: remaining==0 goes to DONE; else GAP if COIN_GAP>0, else SELECT.
- Latency: a delivery sampled at edge N gives coin_valid high from edge N+2.
- GAP: counts COIN_GAP cycles, then goes to SELECT.
- DONE: done=1 for one cycle, then IDLE.
- FAULT: shortfall=1, remaining holds the unpaid amount, done=1 for one cycle, then IDLE. shortfall and remaining hold until the next capture.
- Delivery while busy:
  - If the one-deep pending slot is empty, store change there.
  - If the slot is full, set overrun and discard the new delivery.
  - In IDLE, a non-empty pending slot is taken as if delivery=1, one cycle after the return to IDLE.
  - Delivery arriving in the same cycle as the pending load: the pending value is served first and the new delivery goes into the pending slot.
- Arithmetic: the subtraction never underflows because d<=remaining is guaranteed at SELECT; no wrap-around is possible.

Decomposition:
- Package vm_pkg:
  - Coin code typedef (NONE, RS1, RS2, RS5) with rupee values 1/2/5.
  - FSM state enum with the encodings above.
  - AMT_W default.
- One sub-module, vm_coin_picker: purely combinational; inputs remaining and hopper_empty; outputs coin_type and a none-available flag. Used in SELECT.

Test Plan:
- Rs10 paid for Rs5 item (delivery with change=5), all tubes full, coin_ready=1 -> one RS5 coin, coin_valid first high 2 cycles after delivery, remaining=0, done pulse, shortfall=0.
- change=8, COIN_GAP=1 -> coins RS5, RS2, RS1 in order, one idle cycle between each, done after the third coin.
- change=7 with hopper_empty=100 (Rs5 tube empty) -> RS2, RS2, RS2, RS1; then change=3 with hopper_empty=101 -> one RS2, then FAULT with shortfall=1, remaining=1, done pulse.
- coin_ready held low 5 cycles during ISSUE while hopper_empty toggles -> coin_valid and coin_type stay stable; the coin is counted only on the coin_ready edge.
- Second delivery (change=2) during a payout is served after DONE; a third delivery while the pending slot is full -> overrun=1 and its coins are never issued.
- change=0 -> done in the next cycle, no coin_valid; reset asserted mid-ISSUE -> all outputs 0 immediately, pending slot empty.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared types for the vending machine change dispenser: coin codes,
// FSM state encoding and the default amount width.
package vm_pkg;

    localparam int AMT_W_DEF = 4;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_RS1  = 2'b01,
        COIN_RS2  = 2'b10,
        COIN_RS5  = 2'b11
    } coin_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    function automatic logic [2:0] coin_value(input coin_t c);
        case (c)
            COIN_RS1: return 3'd1;
            COIN_RS2: return 3'd2;
            COIN_RS5: return 3'd5;
            default:  return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vm_coin_picker.sv
// Greedy coin selector: largest denomination that fits the amount owed
// and whose hopper tube still has coins.
module vm_coin_picker
    import vm_pkg::*;
#(
    parameter int AMT_W = AMT_W_DEF
) (
    input  logic [AMT_W-1:0] i_remaining,
    input  logic [2:0]       i_hopper_empty,
    output coin_t            o_coin_type,
    output logic             o_none
);

    always_comb begin
        o_coin_type = COIN_NONE;
        o_none      = 1'b0;
        if (i_remaining >= AMT_W'(5) && !i_hopper_empty[2]) begin
            o_coin_type = COIN_RS5;
        end else if (i_remaining >= AMT_W'(2) && !i_hopper_empty[1]) begin
            o_coin_type = COIN_RS2;
        end else if (i_remaining >= AMT_W'(1) && !i_hopper_empty[0]) begin
            o_coin_type = COIN_RS1;
        end else begin
            o_none = 1'b1;
        end
    end

endmodule

// File: rtl/vm_change_dispenser.sv
// Pays out change one coin per valid/ready handshake, greedily, with a
// one-deep pending slot for deliveries that arrive mid-payout.
module vm_change_dispenser
    import vm_pkg::*;
#(
    parameter int COIN_GAP = 1,
    parameter int AMT_W    = AMT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             delivery,
    input  logic [AMT_W-1:0] change,
    input  logic [2:0]       hopper_empty,
    input  logic             coin_ready,
    output logic             coin_valid,
    output logic [1:0]       coin_type,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] remaining,
    output logic             shortfall,
    output logic             overrun,
    output logic [2:0]       states
);

    localparam bit         HAS_GAP  = (COIN_GAP > 0);
    localparam logic [7:0] GAP_LAST = 8'((COIN_GAP > 0) ? COIN_GAP - 1 : 0);

    state_t           r_state;
    state_t           w_next;
    logic [AMT_W-1:0] r_remaining;
    logic [AMT_W-1:0] r_pend_amt;
    logic             r_pend_valid;
    logic             r_shortfall;
    logic             r_overrun;
    coin_t            r_coin;
    logic [7:0]       r_gap_cnt;

    coin_t            w_pick;
    logic             w_none;
    logic             w_capture;
    logic [AMT_W-1:0] w_cap_amt;
    logic             w_accept;
    logic [AMT_W-1:0] w_rem_after;

    vm_coin_picker #(.AMT_W(AMT_W)) u_picker (
        .i_remaining    (r_remaining),
        .i_hopper_empty (hopper_empty),
        .o_coin_type    (w_pick),
        .o_none         (w_none)
    );

    // A waiting pending entry always wins over a same-cycle delivery.
    assign w_capture   = (r_state == ST_IDLE) && (r_pend_valid || delivery);
    assign w_cap_amt   = r_pend_valid ? r_pend_amt : change;
    assign w_accept    = (r_state == ST_ISSUE) && coin_ready;
    assign w_rem_after = r_remaining - AMT_W'(coin_value(r_coin));

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_capture) begin
                    w_next = (w_cap_amt != '0) ? ST_SELECT : ST_DONE;
                end
            end
            ST_SELECT: w_next = w_none ? ST_FAULT : ST_ISSUE;
            ST_ISSUE: begin
                if (coin_ready) begin
                    if (w_rem_after == '0) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next = HAS_GAP ? ST_GAP : ST_SELECT;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_next = ST_SELECT;
                end
            end
            ST_DONE:  w_next = ST_IDLE;
            ST_FAULT: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_remaining <= '0;
            r_shortfall <= 1'b0;
            r_coin      <= COIN_NONE;
            r_gap_cnt   <= '0;
        end else begin
            if (w_capture) begin
                r_remaining <= w_cap_amt;
                r_shortfall <= 1'b0;
            end else if (w_accept) begin
                r_remaining <= w_rem_after;
            end
            if (r_state == ST_SELECT) begin
                if (w_none) begin
                    r_shortfall <= 1'b1;
                end else begin
                    r_coin <= w_pick;
                end
            end
            r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + 8'd1 : 8'd0;
        end
    end

    // Pending slot: refilled by a delivery in the same IDLE cycle it drains.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend_valid <= 1'b0;
            r_pend_amt   <= '0;
            r_overrun    <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (r_pend_valid) begin
                r_pend_valid <= delivery;
                if (delivery) begin
                    r_pend_amt <= change;
                end
            end
        end else if (delivery) begin
            if (!r_pend_valid) begin
                r_pend_valid <= 1'b1;
                r_pend_amt   <= change;
            end else begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign coin_valid = (r_state == ST_ISSUE);
    assign coin_type  = coin_valid ? r_coin : COIN_NONE;
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE) || (r_state == ST_FAULT);
    assign remaining  = r_remaining;
    assign shortfall  = r_shortfall;
    assign overrun    = r_overrun;
    assign states     = r_state;

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Self-checking bench for vm_change_dispenser: a greedy payout model feeds
// expected coin and completion queues that a negedge monitor drains.
module tb_vm_change_dispenser;
    import vm_pkg::*;

    localparam int AMT_W    = 4;
    localparam int COIN_GAP = 1;

    logic             clk          = 1'b0;
    logic             rst_n        = 1'b0;
    logic             delivery     = 1'b0;
    logic [AMT_W-1:0] change       = '0;
    logic [2:0]       hopper_empty = '0;
    logic             coin_ready   = 1'b0;
    logic             coin_valid;
    logic [1:0]       coin_type;
    logic             busy;
    logic             done;
    logic [AMT_W-1:0] remaining;
    logic             shortfall;
    logic             overrun;
    logic [2:0]       states;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [1:0]     exp_coin_q[$];
    logic [AMT_W:0] exp_done_q[$];
    int             accept_cyc[$];

    vm_change_dispenser #(.COIN_GAP(COIN_GAP), .AMT_W(AMT_W)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .delivery     (delivery),
        .change       (change),
        .hopper_empty (hopper_empty),
        .coin_ready   (coin_ready),
        .coin_valid   (coin_valid),
        .coin_type    (coin_type),
        .busy         (busy),
        .done         (done),
        .remaining    (remaining),
        .shortfall    (shortfall),
        .overrun      (overrun),
        .states       (states)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Greedy reference: pushes the coins and the final {shortfall, remaining}.
    task automatic model_payout(input int amt, input logic [2:0] empty);
        int rem = amt;
        bit stuck = 1'b0;
        while (rem > 0 && !stuck) begin
            if (rem >= 5 && !empty[2]) begin
                exp_coin_q.push_back(2'b11); rem -= 5;
            end else if (rem >= 2 && !empty[1]) begin
                exp_coin_q.push_back(2'b10); rem -= 2;
            end else if (rem >= 1 && !empty[0]) begin
                exp_coin_q.push_back(2'b01); rem -= 1;
            end else begin
                stuck = 1'b1;
            end
        end
        exp_done_q.push_back({stuck, rem[AMT_W-1:0]});
    endtask

    // Returns 1 time unit after the edge that samples the delivery.
    task automatic deliver(input int amt, input bit do_model);
        @(posedge clk); #1;
        delivery = 1'b1;
        change   = AMT_W'(amt);
        if (do_model) model_payout(amt, hopper_empty);
        @(posedge clk); #1;
        delivery = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_coin_q.size() != 0 || exp_done_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check("drain_in_time", {31'b0, n < budget}, 1);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!coin_valid && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("valid_in_time", {31'b0, n < budget}, 1);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (coin_valid && coin_ready) begin
                accept_cyc.push_back(cyc);
                if (exp_coin_q.size() == 0) check("extra_coin", {31'b0, coin_valid}, 0);
                else check("coin_type", {30'b0, coin_type}, {30'b0, exp_coin_q.pop_front()});
            end
            if (done) begin
                if (exp_done_q.size() == 0) check("extra_done", {31'b0, done}, 0);
                else check("done_status", {27'b0, shortfall, remaining}, {27'b0, exp_done_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {coin_valid, coin_type, busy, done, remaining, shortfall, overrun, states}, 0);
        @(negedge clk); rst_n = 1'b1;

        // Single Rs5 coin with first-coin latency.
        hopper_empty = 3'b000; coin_ready = 1'b1;
        deliver(5, 1);
        check("t1_select", {29'b0, states}, 1);
        check("t1_valid_lo", {31'b0, coin_valid}, 0);
        @(posedge clk); #1;
        check("t1_valid_hi", {31'b0, coin_valid}, 1);
        check("t1_type", {30'b0, coin_type}, 3);
        wait_drain(50);
        check("t1_short", {31'b0, shortfall}, 0);

        // Rs8: three coins with gap between acceptances.
        accept_cyc.delete();
        deliver(8, 1);
        wait_drain(100);
        check("t2_ncoins", accept_cyc.size(), 3);
        if (accept_cyc.size() == 3) begin
            check("t2_gap_a", accept_cyc[1] - accept_cyc[0], COIN_GAP + 2);
            check("t2_gap_b", accept_cyc[2] - accept_cyc[1], COIN_GAP + 2);
        end

        // Empty Rs5 tube, then a shortfall.
        hopper_empty = 3'b100;
        deliver(7, 1);
        wait_drain(100);
        hopper_empty = 3'b101;
        deliver(3, 1);
        wait_drain(100);
        repeat (3) @(posedge clk); #1;
        check("t3_short_hold", {31'b0, shortfall}, 1);
        check("t3_rem_hold", {28'b0, remaining}, 1);

        // Stall in ISSUE while hopper flags change.
        hopper_empty = 3'b000; coin_ready = 1'b0;
        deliver(5, 1);
        wait_valid(10);
        repeat (5) begin
            @(posedge clk); #1;
            hopper_empty = 3'($urandom_range(0, 7));
            check("t4_valid", {31'b0, coin_valid}, 1);
            check("t4_type", {30'b0, coin_type}, 3);
            check("t4_rem", {28'b0, remaining}, 5);
        end
        hopper_empty = 3'b000; coin_ready = 1'b1;
        wait_drain(50);

        // Pending slot and overrun: the third delivery must never pay out.
        check("t5_ovr_pre", {31'b0, overrun}, 0);
        deliver(8, 1);
        deliver(2, 1);
        deliver(3, 0);
        wait_drain(200);
        repeat (10) @(posedge clk); #1;
        check("t5_ovr", {31'b0, overrun}, 1);
        check("t5_idle", {31'b0, busy}, 0);
        check("t5_short", {31'b0, shortfall}, 0);

        // Zero change: done right after capture, no coin.
        deliver(0, 1);
        check("t6_done", {31'b0, done}, 1);
        check("t6_state", {29'b0, states}, 4);
        check("t6_novalid", {31'b0, coin_valid}, 0);
        wait_drain(20);

        // Reset mid-ISSUE with a pending entry queued.
        coin_ready = 1'b0;
        deliver(5, 0);
        deliver(2, 0);
        @(posedge clk); #1;
        check("t7_issue", {31'b0, coin_valid}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_outputs", {coin_valid, coin_type, busy, done, remaining, shortfall, overrun, states}, 0);
        exp_coin_q.delete();
        exp_done_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1; coin_ready = 1'b1;
        repeat (10) @(posedge clk); #1;
        check("t7_no_pending", {31'b0, busy}, 0);
        check("t7_ovr_clr", {31'b0, overrun}, 0);
        check("t7_state", {29'b0, states}, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
